// File: rtl/bus_arbiter.sv
// Arbitrates ibus and dbus onto a single-outstanding cbus, holding the grant from issue to data return.
// Define BUS_ARBITER_RR_EN for round-robin tie-breaking; otherwise dbus wins every tie.
module bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  // instruction bus
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [31:0]       i_data,
  // data bus
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_size,
  input  logic [7:0]        d_strobe,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  // shared memory bus
  output logic              c_valid,
  output logic              c_is_write,
  output logic [ADDR_W-1:0] c_addr,
  output logic [2:0]        c_size,
  output logic [7:0]        c_strobe,
  output logic [DATA_W-1:0] c_wdata,
  input  logic              c_ready,
  input  logic              c_rvalid,
  input  logic [DATA_W-1:0] c_rdata,
  output logic              c_owner
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   winner;
  logic   addr_ok_pulse;
  logic   data_ok_pulse;

`ifdef BUS_ARBITER_RR_EN
  // Remembers who completed last so a tie goes to the other requester.
  logic last_q, last_d;

  always_comb begin
    winner = OWNER_I;
    if (i_valid && d_valid) winner = ~last_q;
    else if (d_valid)       winner = OWNER_D;
  end

  always_comb begin
    last_d = last_q;
    if (data_ok_pulse) last_d = owner_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= OWNER_I;
    else        last_q <= last_d;
  end
`else
  always_comb begin
    winner = d_valid ? OWNER_D : OWNER_I;
  end
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    c_valid       = 1'b0;
    addr_ok_pulse = 1'b0;
    data_ok_pulse = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_valid || d_valid) begin
          owner_d = winner;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        c_valid = 1'b1;
        if (c_ready) begin
          addr_ok_pulse = 1'b1;
          if (c_rvalid) begin
            data_ok_pulse = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (c_rvalid) begin
          data_ok_pulse = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments and reset asynchronously on reset low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_I;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Request fields are only presented while the request is on the bus; zero otherwise.
  always_comb begin
    c_addr   = '0;
    c_size   = 3'd0;
    c_strobe = 8'd0;
    c_wdata  = '0;
    if (state_q == ST_REQ) begin
      if (owner_q == OWNER_D) begin
        c_addr   = d_addr;
        c_size   = d_size;
        c_strobe = d_strobe;
        c_wdata  = d_wdata;
      end else begin
        c_addr   = i_addr;
        c_size   = 3'd2;
      end
    end
  end

  assign c_is_write = |c_strobe;
  assign c_owner    = owner_q;

  assign i_addr_ok = addr_ok_pulse && (owner_q == OWNER_I);
  assign d_addr_ok = addr_ok_pulse && (owner_q == OWNER_D);
  assign i_data_ok = data_ok_pulse && (owner_q == OWNER_I);
  assign d_data_ok = data_ok_pulse && (owner_q == OWNER_D);

  // Read data flows straight through; it is forced low only while in reset.
  assign i_data  = reset ? c_rdata[31:0] : 32'd0;
  assign d_rdata = reset ? c_rdata       : '0;

endmodule
